// File: rtl/interval_timer_prog.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_prog
// Description : Programmable-width up/down interval timer with an internal
//               prescaler. A start pulse latches interval/dir/reload, clears
//               the prescaler and loads the start value. Every DIV clock
//               cycles in RUN (pause low) the count steps by one and 'tick'
//               strobes. On reaching the terminal value 'timeout' pulses for
//               one cycle and the timer either reloads (auto-reload) or parks
//               in DONE (one-shot).
//
//               Start value S = dir ? 0 : interval
//               Terminal    T = dir ? interval : 0
//               Control priority: stop > start > pause > tick.
//
// Parameters  : CLOCK_FREQ - master clock frequency in Hz
//               TICK_HZ    - count-tick rate in Hz; DIV = CLOCK_FREQ/TICK_HZ
//                            must be >= 2 and divide exactly
//               CNT_W      - width of interval and count
//
// Ports       : clk       in   master clock, rising edge
//               rst_n     in   asynchronous active-low reset
//               start     in   pulse: latch config, clear prescaler, run
//               stop      in   pulse: abort to IDLE, count cleared
//               pause     in   level: freeze prescaler and count in RUN
//               interval  in   terminal/start magnitude (sampled on start)
//               dir       in   1 = count up, 0 = count down (sampled on start)
//               reload    in   1 = auto-reload, 0 = one-shot (sampled on start)
//               count     out  current count
//               tick      out  one-cycle strobe per prescaled tick in RUN
//               timeout   out  one-cycle pulse on reaching the terminal
//               busy      out  high in RUN
//               done      out  sticky, high in DONE
//
// Optional    : define INTERVAL_TIMER_CAPTURE_EN to add
//               capture   in   pulse: snapshot count in RUN or DONE
//               cap_count out  captured count
//               cap_valid out  one-cycle strobe when cap_count is updated
//
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_prog #(
    parameter int CLOCK_FREQ = 50_000,
    parameter int TICK_HZ    = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [CNT_W-1:0] interval,
    input  logic             dir,
    input  logic             reload,
`ifdef INTERVAL_TIMER_CAPTURE_EN
    input  logic             capture,
    output logic [CNT_W-1:0] cap_count,
    output logic             cap_valid,
`endif
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             timeout,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV  = CLOCK_FREQ / TICK_HZ;
    localparam int c_PS_W = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(c_DIV - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and latched configuration
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_PS_W-1:0] r_ps;
    logic [CNT_W-1:0]  r_count;
    logic              r_tick;
    logic              r_timeout;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_interval;
    logic              r_dir;
    logic              r_reload;

    // Start value from the live inputs (used only in the start cycle)
    logic [CNT_W-1:0]  w_load_val;
    // Start/terminal values from the latched configuration (used in RUN)
    logic [CNT_W-1:0]  w_run_start;
    logic [CNT_W-1:0]  w_run_term;
    logic [CNT_W-1:0]  w_next_cnt;
    logic              w_zero_run;
    logic              w_ps_last;

    assign w_load_val  = dir   ? '0 : interval;
    assign w_run_start = r_dir ? '0 : r_interval;
    assign w_run_term  = r_dir ? r_interval : '0;
    assign w_next_cnt  = r_dir ? (r_count + 1'b1) : (r_count - 1'b1);
    // With interval 0 the start value already equals the terminal, so the
    // run finishes immediately instead of stepping away from it.
    assign w_zero_run  = (r_interval == '0);
    assign w_ps_last   = (r_ps == c_PS_LAST);

    // ------------------------------------------------------------------------
    // Main sequencer: prescaler, counter and FSM, all outputs registered
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_ps       <= '0;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_interval <= '0;
            r_dir      <= 1'b0;
            r_reload   <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
            r_timeout <= 1'b0;

            if (stop) begin
                r_state <= c_ST_IDLE;
                r_ps    <= '0;
                r_count <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (start) begin
                // Restart from any state; a pending tick in RUN is dropped.
                r_interval <= interval;
                r_dir      <= dir;
                r_reload   <= reload;
                r_ps       <= '0;
                r_count    <= w_load_val;
                r_state    <= c_ST_RUN;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_RUN: begin
                        if (w_zero_run) begin
                            // Single timeout, no reload even in auto-reload
                            // mode, to avoid a per-cycle pulse train.
                            r_timeout <= 1'b1;
                            r_state   <= c_ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (!pause) begin
                            if (w_ps_last) begin
                                r_ps   <= '0;
                                r_tick <= 1'b1;
                                if (w_next_cnt == w_run_term) begin
                                    r_timeout <= 1'b1;
                                    if (r_reload) begin
                                        // Terminal is never displayed in
                                        // auto-reload: jump straight to S.
                                        r_count <= w_run_start;
                                    end else begin
                                        r_count <= w_run_term;
                                        r_state <= c_ST_DONE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end
                                end else begin
                                    r_count <= w_next_cnt;
                                end
                            end else begin
                                r_ps <= r_ps + 1'b1;
                            end
                        end
                    end
                    c_ST_IDLE: begin
                        // Waiting for start; nothing to update.
                    end
                    c_ST_DONE: begin
                        // Count holds the terminal until start or stop.
                    end
                    default: begin
                        // Unreachable encoding: recover to IDLE.
                        r_state <= c_ST_IDLE;
                        r_ps    <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign timeout = r_timeout;
    assign busy    = r_busy;
    assign done    = r_done;

`ifdef INTERVAL_TIMER_CAPTURE_EN
    // ------------------------------------------------------------------------
    // Count capture: snapshots the registered count, i.e. the value before
    // any update happening on the same edge.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cap_count;
    logic             r_cap_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_count <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_cap_valid <= 1'b0;
            if (capture && ((r_state == c_ST_RUN) || (r_state == c_ST_DONE))) begin
                r_cap_count <= r_count;
                r_cap_valid <= 1'b1;
            end
        end
    end

    assign cap_count = r_cap_count;
    assign cap_valid = r_cap_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer_prog
// Description : Self-checking bench for interval_timer_prog (DIV = 8, 4-bit).
//               Expected tick/timeout events are queued when a run is started
//               and compared as the DUT produces them; end-of-run state comes
//               from a vector table. Hand sequences cover reset, pause,
//               restart, start+stop and capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer_prog;

    localparam int c_DIV = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       pause    = 1'b0;
    logic [3:0] interval = 4'd0;
    logic       dir      = 1'b0;
    logic       reload   = 1'b0;
    logic [3:0] count;
    logic       tick;
    logic       timeout;
    logic       busy;
    logic       done;
`ifdef INTERVAL_TIMER_CAPTURE_EN
    logic       capture  = 1'b0;
    logic [3:0] cap_count;
    logic       cap_valid;
`endif

    interval_timer_prog #(
        .CLOCK_FREQ (8),
        .TICK_HZ    (1),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .interval (interval),
        .dir      (dir),
        .reload   (reload),
`ifdef INTERVAL_TIMER_CAPTURE_EN
        .capture  (capture),
        .cap_count(cap_count),
        .cap_valid(cap_valid),
`endif
        .count    (count),
        .tick     (tick),
        .timeout  (timeout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; stable when sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int n_to     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        bit         tk;
        bit         to;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [3:0] iv;
        bit         d;
        bit         rl;
        int         ncyc;
        logic [3:0] e_count;
        bit         e_busy;
        bit         e_done;
        int         e_to;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int cnt, input bit tk, input bit to);
        ev_t e;
        e.cyc = c;
        e.cnt = 4'(cnt);
        e.tk  = tk;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    // Expected events for a run started on edge st, up to edge st+ncyc.
    task automatic push_run(input logic [3:0] iv, input bit d, input bit rl,
                            input int st, input int ncyc);
        int s;
        int t;
        int c;
        s = d ? 0 : int'(iv);
        t = d ? int'(iv) : 0;
        c = s;
        if (iv == 4'd0) begin
            if (ncyc >= 1) push_ev(st + 1, t, 1'b0, 1'b1);
            return;
        end
        for (int k = 1; k * c_DIV <= ncyc; k++) begin
            c = d ? c + 1 : c - 1;
            if (c == t) begin
                push_ev(st + c_DIV * k, rl ? s : t, 1'b1, 1'b1);
                if (!rl) break;
                c = s;
            end else begin
                push_ev(st + c_DIV * k, c, 1'b1, 1'b0);
            end
        end
    endtask

    // Event monitor / scoreboard consumer.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (tick || timeout)) begin
            if (timeout) n_to++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_count", int'(count), int'(e.cnt));
                check("ev_tick", int'(tick), int'(e.tk));
                check("ev_timeout", int'(timeout), int'(e.to));
            end
        end
    end

    // Drive a start pulse; returns the edge index on which it is sampled.
    task automatic start_run(input logic [3:0] iv, input bit d, input bit rl,
                             input int npush, output int st);
        interval = iv;
        dir      = d;
        reload   = rl;
        start    = 1'b1;
        st       = cyc + 1;
        push_run(iv, d, rl, st, npush);
        @(negedge clk);
        start    = 1'b0;
        interval = ~iv;
        dir      = ~d;
        reload   = ~rl;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        check("stop_count", int'(count), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int st2;

        //          iv    d     rl    ncyc cnt   busy  done  to
        vecs[0] = '{4'd3, 1'b1, 1'b0, 40, 4'd3, 1'b0, 1'b1, 1};
        vecs[1] = '{4'd2, 1'b0, 1'b1, 40, 4'd1, 1'b1, 1'b0, 2};
        vecs[2] = '{4'd5, 1'b0, 1'b0, 48, 4'd0, 1'b0, 1'b1, 1};
        vecs[3] = '{4'd4, 1'b1, 1'b1, 36, 4'd0, 1'b1, 1'b0, 1};
        vecs[4] = '{4'd0, 1'b1, 1'b1, 20, 4'd0, 1'b0, 1'b1, 1};
        vecs[5] = '{4'd15,1'b1, 1'b0, 20, 4'd2, 1'b1, 1'b0, 0};
        vecs[6] = '{4'd1, 1'b0, 1'b1, 24, 4'd1, 1'b1, 1'b0, 3};
        vecs[7] = '{4'd0, 1'b0, 1'b0, 5,  4'd0, 1'b0, 1'b1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs
        foreach (vecs[i]) begin
            n_to = 0;
            start_run(vecs[i].iv, vecs[i].d, vecs[i].rl, vecs[i].ncyc, st);
            wait_until(st + vecs[i].ncyc);
            check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].e_count));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
            check($sformatf("vec%0d_timeouts", i), n_to, vecs[i].e_to);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
            do_stop();
        end

        // Reset asserted mid-run: async clear, no timeout afterwards
        start_run(4'd3, 1'b1, 1'b0, 8, st);
        wait_until(st + 12);
        check("prerst_count", int'(count), 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_count", int'(count), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_tick", int'(tick), 0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_to  = 0;
        wait_until(cyc + 30);
        check("postrst_busy", int'(busy), 0);
        check("postrst_count", int'(count), 0);
        check("postrst_timeouts", n_to, 0);

        // Pause: 20-cycle freeze after first tick, then a 1-cycle pause on a
        // pending tick
        start_run(4'd5, 1'b1, 1'b0, 0, st);
        push_ev(st + 8, 1, 1'b1, 1'b0);
        push_ev(st + 36, 2, 1'b1, 1'b0);
        push_ev(st + 45, 3, 1'b1, 1'b0);
        wait_until(st + 8);
        pause = 1'b1;
        wait_until(st + 28);
        check("pause_hold_count", int'(count), 1);
        pause = 1'b0;
        wait_until(st + 43);
        pause = 1'b1;
        wait_until(st + 44);
        check("pause_suppress_count", int'(count), 2);
        check("pause_suppress_tick", int'(tick), 0);
        pause = 1'b0;
        wait_until(st + 45);
        check("pause_resume_count", int'(count), 3);
        check("pause_pending", exp_q.size(), 0);
        do_stop();

        // Restart during RUN: count reloads, prescaler cleared
        start_run(4'd3, 1'b1, 1'b0, 12, st);
        wait_until(st + 12);
        n_to = 0;
        start_run(4'd3, 1'b0, 1'b0, 10, st2);
        check("restart_count", int'(count), 3);
        check("restart_busy", int'(busy), 1);
        check("restart_timeout", int'(timeout), 0);
        wait_until(st2 + 10);
        check("restart_count2", int'(count), 2);
        check("restart_timeouts", n_to, 0);
        check("restart_pending", exp_q.size(), 0);
        do_stop();

        // Start and stop together, from RUN and from IDLE
        start_run(4'd2, 1'b1, 1'b1, 0, st);
        wait_until(st + 5);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check("ss_run_busy", int'(busy), 0);
        check("ss_run_count", int'(count), 0);
        start = 1'b1;
        stop  = 1'b1;
        interval = 4'd1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wait_until(cyc + 12);
        check("ss_idle_busy", int'(busy), 0);
        check("ss_idle_done", int'(done), 0);

        // Restart from DONE clears done
        start_run(4'd1, 1'b1, 1'b0, 8, st);
        wait_until(st + 10);
        check("done_flag", int'(done), 1);
        check("done_count", int'(count), 1);
        start_run(4'd2, 1'b0, 1'b1, 0, st2);
        check("redone_done", int'(done), 0);
        check("redone_busy", int'(busy), 1);
        check("redone_count", int'(count), 2);
        do_stop();

`ifdef INTERVAL_TIMER_CAPTURE_EN
        // Capture coincident with the tick that moves count 2 -> 3
        start_run(4'd5, 1'b1, 1'b0, 24, st);
        wait_until(st + 23);
        capture = 1'b1;
        wait_until(st + 24);
        capture = 1'b0;
        check("cap_valid", int'(cap_valid), 1);
        check("cap_count", int'(cap_count), 2);
        check("cap_live_count", int'(count), 3);
        wait_until(st + 25);
        check("cap_valid_pulse", int'(cap_valid), 0);
        do_stop();
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        #1;
        check("cap_idle_valid", int'(cap_valid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
